// File: rtl/mem_stream_pkg.sv
// Shared types and MMIO constants for the data-memory byte streamer.
// S_WRLED exists only when MEM_STREAM_LED_EN is defined.
package mem_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
`ifdef MEM_STREAM_LED_EN
        S_WRLED = 3'd3,
`endif
        S_FIN   = 3'd4
    } state_t;

    localparam logic [31:0] LED_MMIO_ADDR = 32'h4000000C;
    localparam logic [31:0] SEG_MMIO_ADDR = 32'h40000010;
    localparam logic [7:0]  NUL_BYTE      = 8'h00;

endpackage

// File: rtl/mem_byte_streamer.sv
// Reads a byte string from data memory with byte loads and streams it out on valid/ready.
// MEM_STREAM_LED_EN adds a final LED MMIO write of the byte count on normal completion.
module mem_byte_streamer
    import mem_stream_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 512,
    parameter logic [7:0]  TERM_CHAR = 8'h0A
`ifdef MEM_STREAM_LED_EN
    , parameter logic [31:0] LED_ADDR = LED_MMIO_ADDR
`endif
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [9:0]  byte_count,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Address,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        lbflag,
    output logic [31:0] Write_Data,
    input  logic [31:0] Read_Data
);

    localparam logic [9:0] MAX_CNT = 10'(MAX_LEN);

    state_t      state_q;
    logic [31:0] ptr_q;
    logic [9:0]  cnt_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] addr_q;
    logic        rd_q;
    logic        lb_q;
    logic [9:0]  cnt_inc;
    logic        last_byte;
    logic        unused_rd_hi;

    assign cnt_inc      = cnt_q + 10'd1;
    assign last_byte    = (data_q == TERM_CHAR) || (cnt_inc == MAX_CNT);
    assign unused_rd_hi = ^Read_Data[31:8];

`ifdef MEM_STREAM_LED_EN
    logic        wr_q;
    logic [31:0] wdata_q;
    assign MemWrite   = wr_q;
    assign Write_Data = wdata_q;
`else
    assign MemWrite   = 1'b0;
    assign Write_Data = '0;
`endif

    // Memory-side outputs default to zero every cycle; only the state being
    // entered drives them, so they are valid exactly while in FETCH/WRLED.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            lb_q    <= 1'b0;
`ifdef MEM_STREAM_LED_EN
            wr_q    <= 1'b0;
            wdata_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            addr_q <= '0;
            rd_q   <= 1'b0;
            lb_q   <= 1'b0;
`ifdef MEM_STREAM_LED_EN
            wr_q    <= 1'b0;
            wdata_q <= '0;
`endif
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_FETCH;
                            ptr_q   <= base_addr;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            addr_q  <= base_addr;
                            rd_q    <= 1'b1;
                            lb_q    <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (Read_Data[7:0] == NUL_BYTE) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SEND;
                            data_q  <= Read_Data[7:0];
                            valid_q <= 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (out_ready) begin
                            cnt_q   <= cnt_inc;
                            ptr_q   <= ptr_q + 32'd1;
                            valid_q <= 1'b0;
                            if (last_byte) begin
`ifdef MEM_STREAM_LED_EN
                                state_q <= S_WRLED;
                                addr_q  <= LED_ADDR;
                                wr_q    <= 1'b1;
                                wdata_q <= {22'b0, cnt_inc};
`else
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
`endif
                            end else begin
                                state_q <= S_FETCH;
                                addr_q  <= ptr_q + 32'd1;
                                rd_q    <= 1'b1;
                                lb_q    <= 1'b1;
                            end
                        end
                    end
`ifdef MEM_STREAM_LED_EN
                    S_WRLED: begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end
`endif
                    S_FIN: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = cnt_q;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign Address    = addr_q;
    assign MemRead    = rd_q;
    assign lbflag     = lb_q;

endmodule

// File: doc/mem_byte_streamer.md
# mem_byte_streamer

Bus initiator for the data-memory port: reads a byte string from data memory using byte-load accesses and emits it one byte at a time on a valid/ready stream. A string ends at a terminator character, a NUL byte, or a length limit. It sits beside the CPU memory stage and drives the same Address/MemRead/MemWrite/lbflag/Write_Data signals the data memory responds to. It consumes the memory's combinational Read_Data.

## Interface
- MAX_LEN, 512: maximum bytes emitted per run (1..1023).
- TERM_CHAR, 8'h0A: terminator byte; it is emitted, then the run ends.
- LED_ADDR, 32'h4000000C: LED MMIO address, used only under the macro.
- sysclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel the run; sampled in any non-IDLE state.
- base_addr  in  32  byte address of the first character; sampled with start.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at normal run completion.
- byte_count  out  10  bytes emitted in the current or last run.
- out_data  out  8  stream byte.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- Address  out  32  memory byte address.
- MemRead  out  1  read enable.
- MemWrite  out  1  write enable.
- lbflag  out  1  byte-load select.
- Write_Data  out  32  store data.
- Read_Data  in  32  memory read data; combinational, valid in the same cycle.

## Operation
- States:
  - IDLE.
  - FETCH: Address = ptr, MemRead = 1, lbflag = 1. Capture Read_Data[7:0] at the clock edge.
  - SEND: out_valid = 1; out_data is held from the register.
  - WRLED: present only under the macro.
  - FIN.
- IDLE: start = 1 → ptr ← base_addr, byte_count ← 0, go to FETCH.
- FETCH, by captured byte:
  - 0x00: go to FIN; the byte is not emitted and the count is unchanged.
  - Any other value: go to SEND.
- SEND: a handshake (valid & ready at an edge) increments byte_count and ptr (32-bit, wraps 2^32→0). Then:
  - Byte == TERM_CHAR, or byte_count reaches MAX_LEN: go to FIN (or WRLED).
  - Otherwise: go to FETCH.
- FIN: done = 1 for one cycle, then IDLE.
- abort = 1 in any non-IDLE state: next state is IDLE; no done, no LED write.
  - abort wins over a simultaneous handshake; that byte is not counted.
- In IDLE, byte_count holds the last value; start is ignored while busy.
- When not in FETCH or WRLED: Address = 0, MemRead = 0, lbflag = 0, MemWrite = 0, Write_Data = 0.

## Timing
- Reset values: state IDLE; busy 0; done 0; byte_count 0; out_data 0; out_valid 0; all memory outputs 0. Reset takes effect immediately when asserted mid-run; there is no trailing done or write.
- start edge → FETCH in the next cycle → out_valid in the cycle after that.
- Throughput: one byte per 2 cycles with ready held high.
- Under backpressure, out_valid and out_data are stable until the handshake.
- Last handshake → done pulse 1 cycle later (2 cycles with WRLED).

## Configuration
- MEM_STREAM_LED_EN:
  - Defined: on normal completion, WRLED drives one cycle of Address = LED_ADDR, MemWrite = 1, Write_Data = {22'b0, byte_count}, MemRead = 0. FIN follows.
  - Undefined: WRLED does not exist and MemWrite is constant 0.

## Structure
- Package mem_stream_pkg holds the state enum, the LED_ADDR and 32'h40000010 MMIO constants, and the NUL constant.
- Single module; no sub-module needed. The FSM, pointer, and counter are all local.

## Test plan
- Memory word 12 = 0x00000a78, base 48, ready high → bytes 0x78, 0x0A; byte_count 2; done pulses once.
- Words 0..12 as power-on image, base 0 → 50 bytes, starting 0x6C, 0x69, 0x6E, 0x75 and ending 0x78, 0x0A; byte_count 50.
- Word 100 = 0x78696e75, word 101 = 0, base 400 → 0x75, 0x6E, 0x69, 0x78 then NUL; byte_count 4; NUL not emitted.
- ready low for 5 cycles mid-string → out_valid and out_data stable; no count change. With MAX_LEN = 3 and base 0 → 3 bytes, done.
- abort during SEND together with ready → IDLE next cycle, no done, count not incremented. reset low mid-run → all outputs 0 immediately.
- MEM_STREAM_LED_EN defined, base 0 → one write of 0x00000032 to 0x4000000C, then done.
